// File: rtl/bin_maxpool2x2.sv
// ============================================================================
// Module   : bin_maxpool2x2
// Function : 2x2 stride-2 binary max-pool (window OR) from one SRAM region to
//            another; optional threshold-popcount mode via BIN_MAXPOOL_THRESH_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bin_maxpool2x2 #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pool_run,
    output logic              pool_busy,
    output logic              pool_done,
    input  logic [ADDR_W-1:0] cfg_rd_base,
    input  logic [ADDR_W-1:0] cfg_wr_base,
    input  logic [4:0]        cfg_cols,
    input  logic [4:0]        cfg_rows,
`ifdef BIN_MAXPOOL_THRESH_EN
    input  logic [2:0]        cfg_thresh,
`endif
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int c_PAIRS = DATA_W / 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_n;        // edges elapsed since the start edge
    logic [4:0]        r_rows;     // effective row count, 0 for a degenerate job
    logic [4:0]        r_half;     // pooled output columns
    logic [ADDR_W-1:0] r_wr_base;
    logic [DATA_W-1:0] r_row_a;
    logic [DATA_W-1:0] w_pooled;
    logic              w_degen;
    logic              w_sample;
    logic              w_last_rd;
    logic              w_finish;
`ifdef BIN_MAXPOOL_THRESH_EN
    logic [2:0]        r_thresh;
`endif

    assign w_degen   = (cfg_cols < 5'd2) || (cfg_rows < 5'd2);
    assign w_sample  = (r_state != S_IDLE) && (r_n < r_rows);
    assign w_last_rd = (r_n + 5'd1) == (r_rows - 5'd1);
    assign w_finish  = (r_state == S_DRAIN) && (r_n == r_rows);

    // Odd row arrives live on rd_data and is combined with the captured even row.
    always_comb begin
        w_pooled = '0;
        for (int j = 0; j < c_PAIRS; j++) begin
            if (j < int'(r_half)) begin
`ifdef BIN_MAXPOOL_THRESH_EN
                w_pooled[j] = (3'(r_row_a[2*j]) + 3'(r_row_a[2*j+1]) +
                               3'(rd_data[2*j]) + 3'(rd_data[2*j+1])) >= r_thresh;
`else
                w_pooled[j] = r_row_a[2*j] | r_row_a[2*j+1] |
                              rd_data[2*j] | rd_data[2*j+1];
`endif
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (pool_run)  w_state_nxt = w_degen ? S_DRAIN : S_READ;
            S_READ:  if (w_last_rd) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_finish)  w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pool_busy <= 1'b0;
            pool_done <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            r_n       <= '0;
            r_rows    <= '0;
            r_half    <= '0;
            r_wr_base <= '0;
            r_row_a   <= '0;
`ifdef BIN_MAXPOOL_THRESH_EN
            r_thresh  <= '0;
`endif
        end else begin
            wr_en     <= 1'b0;
            pool_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pool_run) begin
                        pool_busy <= 1'b1;
                        r_n       <= '0;
                        r_wr_base <= cfg_wr_base;
                        r_half    <= {1'b0, cfg_cols[4:1]};
                        r_rows    <= w_degen ? 5'd0 : {cfg_rows[4:1], 1'b0};
                        if (!w_degen) begin
                            rd_addr <= cfg_rd_base;
                        end
`ifdef BIN_MAXPOOL_THRESH_EN
                        r_thresh <= (cfg_thresh == 3'd0) ? 3'd1 :
                                    (cfg_thresh > 3'd4)  ? 3'd4 : cfg_thresh;
`endif
                    end
                end
                S_READ, S_DRAIN: begin
                    r_n <= r_n + 5'd1;
                    if (r_state == S_READ) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                    if (w_sample) begin
                        if (!r_n[0]) begin
                            r_row_a <= rd_data;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= r_wr_base + ADDR_W'(r_n[4:1]);
                            wr_data <= w_pooled;
                        end
                    end
                    if (w_finish) begin
                        pool_busy <= 1'b0;
                        pool_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/bin_maxpool2x2.md
Name: bin_maxpool2x2

Overview:
- Downstream stage of the binary XNOR 3x3 convolution engine.
- Reads binary feature-map rows that the convolution wrote to the output SRAM (one row per word, bit i = column i).
- Applies 2x2 stride-2 binary max-pooling, i.e. the OR of each 2x2 window.
- Writes the pooled rows to a second SRAM region. Start/busy control follows the same run/busy style as the convolution engine.

Parameters:
ADDR_W, 12, SRAM address width; all address arithmetic is modulo 2^ADDR_W.
DATA_W, 16, SRAM word width; also the maximum column count.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pool_run  in  1  start request; sampled only in IDLE
pool_busy  out  1  high from the start edge until the done edge
pool_done  out  1  one-cycle pulse when the job completes
cfg_rd_base  in  ADDR_W  address of input row 0; latched at start
cfg_wr_base  in  ADDR_W  address of pooled row 0; latched at start
cfg_cols  in  5  input columns (2..DATA_W); latched at start
cfg_rows  in  5  input rows (2..16); latched at start
rd_addr  out  ADDR_W  registered read address
rd_data  in  DATA_W  read data; valid the cycle after rd_addr is presented
wr_en  out  1  registered write enable
wr_addr  out  ADDR_W  registered write address
wr_data  out  DATA_W  registered write data

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high; both are fixed.
- Reset values: all outputs 0; FSM in IDLE.
- Reset asserted mid-job: the job is aborted. At the next edge all outputs are 0 and the FSM is in IDLE; no done pulse is generated.
- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ: edge T0 samples pool_run=1. At T0: cfg latched, pool_busy=1, rd_addr=cfg_rd_base.
  - READ: rd_addr increments by 1 each edge until address rd_base+R-1 has been issued, then holds.
  - READ -> DRAIN: at the edge that presents the last read address.
  - DRAIN -> IDLE: at the edge of the last write. At that edge pool_busy=0 and pool_done=1 (one cycle).
  - pool_run in READ or DRAIN: ignored.
- Effective sizes: C = cfg_cols & ~1, R = cfg_rows & ~1. An odd trailing row or column is discarded.
- Degenerate job (C<2 or R<2): no reads and no writes. pool_busy=1 for exactly one cycle, then pool_done pulses.
- Read timing: data for read k (address rd_base+k, set at edge T0+k) is sampled from rd_data at edge T0+k+1.
- Row handling:
  - Even rows are captured into row_a.
  - At the edge that samples the odd row 2i+1: v = row_a | rd_data, combinational on rd_data.
  - At that same edge T0+2i+2, the write is registered: wr_en=1, wr_addr=wr_base+i, wr_data[j]=v[2j]|v[2j+1] for j<C/2, and wr_data[DATA_W-1:C/2]=0.
- wr_en is high for exactly one cycle per pooled row; it is low in all other cycles.
- Last write at edge T0+R. Done edge (pool_busy falls, pool_done pulses) is T0+R+1. Total busy cycles = R+1.
- Address wrap: rd_addr and wr_addr wrap modulo 2^ADDR_W with no error.
- pool_done and pool_run at the same edge: the new start is taken only at a later edge where IDLE samples pool_run.

Optional Feature:
- Macro: BIN_MAXPOOL_THRESH_EN.
- Defined:
  - Adds input port cfg_thresh[2:0], latched at start.
  - Each output bit = 1 iff the popcount of its 2x2 window >= cfg_thresh.
  - cfg_thresh=0 is treated as 1; values above 4 are treated as 4.
  - The popcount uses both the captured even row and the live odd row, with the same timing.
- Undefined:
  - The port does not exist.
  - Output is the plain OR of the window, equivalent to threshold 1.

Test Plan:
1. cols=14, rows=14, rd_base=0, wr_base=0x100, all rows 0x3FFF -> 7 writes at addresses 0x100..0x106, each wr_data=0x007F; pool_busy high 15 cycles; one pool_done pulse.
2. cols=8, rows=8; row0=0x01, rows1..7=0x00 -> wr_data at wr_base = 0x0001, rows 1..3 write 0x0000. Repeat with row1=0x80 only -> wr_data at wr_base = 0x0008.
3. cols=10, rows=9, row8 nonzero -> exactly 4 writes; row8 is never read (last rd_addr = rd_base+7); wr_data[15:5]=0.
4. cols=1, rows=14 -> no reads, no writes; pool_busy high 1 cycle, pool_done 1 cycle. Then pool_run pulsed again while busy on a valid job -> second request ignored.
5. rd_base=0xFFE, wr_base=0xFFF, rows=4, cols=4 -> reads 0xFFE,0xFFF,0x000,0x001; writes 0xFFF then 0x000. A reset asserted after the first write -> outputs 0 next edge, no pool_done.
6. BIN_MAXPOOL_THRESH_EN: window bits 1,1,1,0. thresh=3 -> 1; thresh=4 -> 0; thresh=0 -> 1; thresh=7 -> 0.
